// File: rtl/lfsr_dither_sched.sv
// Bring-up sequencer and round-robin word arbiter for the tiny SRL LFSR in the AGC dither path.
// Optional zero-word lockup detector enabled by defining LFSR_LOCKUP_DETECT_EN.
module lfsr_dither_sched #(
    parameter int NUM_REQ       = 4,
    parameter int FLUSH_CYCLES  = 16,
    parameter int WARMUP_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               restart_i,
    output logic               lfsr_rst_o,
    output logic               lfsr_start_o,
    input  logic [2:0]         lfsr_out_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [2:0]         data_o,
    output logic               running_o,
    output logic [CNT_W-1:0]   issued_o,
    output logic               lockup_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SEQ_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_SEED   = 3'd2;
    localparam logic [2:0] S_WARMUP = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]         data_q, data_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               lfsr_rst_q, lfsr_rst_d;
    logic               lfsr_start_q, lfsr_start_d;
    logic               running_q, running_d;
    logic               lockup_q, lockup_d;
    logic               lockup_hit;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

`ifdef LFSR_LOCKUP_DETECT_EN
    logic [5:0] zero_cnt_q, zero_cnt_d;

    // 40 consecutive zero words exceeds the LFSR length: the register has collapsed.
    always_comb begin
        zero_cnt_d = '0;
        lockup_hit = 1'b0;
        if (state_q == S_RUN && lfsr_out_i == 3'b000) begin
            if (zero_cnt_q == 6'd39) lockup_hit = 1'b1;
            else                     zero_cnt_d = zero_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) zero_cnt_q <= '0;
        else         zero_cnt_q <= zero_cnt_d;
    end
`else
    assign lockup_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        data_d    = data_q;
        issued_d  = issued_q;
        lockup_d  = lockup_q | lockup_hit;
        if (restart_i) begin
            issued_d = '0;
            lockup_d = 1'b0;
        end
        if (!enable_i) begin
            state_d = S_IDLE;
        end else if (restart_i && state_q != S_IDLE) begin
            state_d   = S_FLUSH;
            seq_cnt_d = SEQ_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_FLUSH;
                    seq_cnt_d = SEQ_W'(FLUSH_CYCLES - 1);
                end
                S_FLUSH: begin
                    if (seq_cnt_q == '0) state_d = S_SEED;
                    else                 seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
                S_SEED: begin
                    state_d   = S_WARMUP;
                    seq_cnt_d = SEQ_W'(WARMUP_CYCLES - 1);
                end
                S_WARMUP: begin
                    if (seq_cnt_q == '0) state_d = S_RUN;
                    else                 seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
                S_RUN: begin
                    if (lockup_hit) begin
                        state_d   = S_FLUSH;
                        seq_cnt_d = SEQ_W'(FLUSH_CYCLES - 1);
                    end else if (win_vld) begin
                        gnt_d[win_idx] = 1'b1;
                        data_d         = lfsr_out_i;
                        ptr_d          = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
                        if (issued_q != '1) issued_d = issued_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        lfsr_rst_d   = (state_d == S_IDLE) || (state_d == S_FLUSH);
        lfsr_start_d = (state_d == S_SEED);
        running_d    = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            seq_cnt_q    <= '0;
            ptr_q        <= '0;
            gnt_q        <= '0;
            data_q       <= '0;
            issued_q     <= '0;
            lfsr_rst_q   <= 1'b1;
            lfsr_start_q <= 1'b0;
            running_q    <= 1'b0;
            lockup_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            data_q       <= data_d;
            issued_q     <= issued_d;
            lfsr_rst_q   <= lfsr_rst_d;
            lfsr_start_q <= lfsr_start_d;
            running_q    <= running_d;
            lockup_q     <= lockup_d;
        end
    end

    assign lfsr_rst_o   = lfsr_rst_q;
    assign lfsr_start_o = lfsr_start_q;
    assign gnt_o        = gnt_q;
    assign data_o       = data_q;
    assign running_o    = running_q;
    assign issued_o     = issued_q;
    assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_dither_sched.sv
// Scoreboard bench for lfsr_dither_sched: bring-up timing, round-robin grants, restart/enable, lockup.
module tb_lfsr_dither_sched;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        restart_i;
    logic        lfsr_rst_o;
    logic        lfsr_start_o;
    logic [2:0]  lfsr_out_i;
    logic [3:0]  req_i;
    logic [3:0]  gnt_o;
    logic [2:0]  data_o;
    logic        running_o;
    logic [31:0] issued_o;
    logic        lockup_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0]  exp_q[$];
    int          m_ptr = 0;
    logic [2:0]  m_data = 3'd0;
    int          m_issued = 0;

    lfsr_dither_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .restart_i(restart_i),
        .lfsr_rst_o(lfsr_rst_o), .lfsr_start_o(lfsr_start_o), .lfsr_out_i(lfsr_out_i),
        .req_i(req_i), .gnt_o(gnt_o), .data_o(data_o), .running_o(running_o),
        .issued_o(issued_o), .lockup_o(lockup_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One RUN cycle: model the arbiter, push expectation, then compare the registered result.
    task automatic run_cycle(input logic [3:0] req, input logic [2:0] word);
        logic [3:0] eg;
        logic [6:0] e;
        req_i      = req;
        lfsr_out_i = word;
        eg = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (eg == 4'b0000 && req[(m_ptr + i) % 4]) begin
                eg[(m_ptr + i) % 4] = 1'b1;
                m_ptr    = ((m_ptr + i) % 4 + 1) % 4;
                m_data   = word;
                m_issued = m_issued + 1;
            end
        end
        exp_q.push_back({eg, m_data});
        step();
        e = exp_q.pop_front();
        check_val("gnt", gnt_o, e[6:3]);
        check_val("data", data_o, e[2:0]);
    endtask

    // Starting at the first sample after the triggering edge, measure flush/seed/warm-up.
    task automatic bringup(input string tag);
        int   n;
        logic gseen;
        gseen = 1'b0;
        req_i = 4'b1111;
        n = 0;
        while (lfsr_rst_o === 1'b1 && n < 300) begin
            if (gnt_o != 4'b0) gseen = 1'b1;
            n++;
            lfsr_out_i = 3'($urandom_range(7));
            step();
        end
        check_val({tag, "_flush_len"}, n, 16);
        n = 0;
        while (lfsr_start_o === 1'b1 && lfsr_rst_o === 1'b0 && n < 300) begin
            if (gnt_o != 4'b0) gseen = 1'b1;
            n++;
            step();
        end
        check_val({tag, "_seed_len"}, n, 1);
        n = 0;
        while (running_o === 1'b0 && lfsr_rst_o === 1'b0 && lfsr_start_o === 1'b0 && n < 300) begin
            if (gnt_o != 4'b0) gseen = 1'b1;
            n++;
            lfsr_out_i = 3'($urandom_range(7));
            step();
        end
        check_val({tag, "_warmup_len"}, n, 64);
        check_val({tag, "_running"}, running_o, 1'b1);
        if (gnt_o != 4'b0) gseen = 1'b1;
        check_val({tag, "_no_early_gnt"}, gseen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; restart_i = 1'b0;
        req_i = 4'b0; lfsr_out_i = 3'd0;
        repeat (3) step();
        check_val("rst_lfsr_rst", lfsr_rst_o, 1'b1);
        check_val("rst_start", lfsr_start_o, 1'b0);
        check_val("rst_gnt", gnt_o, 4'b0);
        check_val("rst_data", data_o, 3'd0);
        check_val("rst_running", running_o, 1'b0);
        check_val("rst_issued", issued_o, 32'd0);
        check_val("rst_lockup", lockup_o, 1'b0);
        rst_ni = 1'b1;
        step();
        check_val("idle_lfsr_rst", lfsr_rst_o, 1'b1);

        // Bring-up from IDLE
        enable_i = 1'b1;
        step();
        bringup("boot");

        // All four requesting: strict rotation
        for (int k = 0; k < 8; k++) run_cycle(4'b1111, 3'($urandom_range(7)));
        check_val("issued_8", issued_o, 32'd8);

        // Single requester every cycle, then pointer wrap
        for (int k = 0; k < 3; k++) run_cycle(4'b0100, 3'($urandom_range(7)));
        run_cycle(4'b1001, 3'($urandom_range(7)));
        run_cycle(4'b1001, 3'($urandom_range(7)));
        run_cycle(4'b0000, 3'($urandom_range(7)));
        while (m_issued < 20) run_cycle(4'b1111, 3'($urandom_range(7)));
        check_val("issued_20", issued_o, 32'd20);

        // Restart in RUN
        req_i = 4'b1111;
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        m_issued = 0;
        check_val("restart_gnt", gnt_o, 4'b0);
        check_val("restart_issued", issued_o, 32'd0);
        check_val("restart_lfsr_rst", lfsr_rst_o, 1'b1);
        bringup("restart");

        for (int k = 0; k < 3; k++) run_cycle(4'b0001, 3'($urandom_range(7)));
        check_val("issued_3", issued_o, 32'd3);

        // Disable in RUN keeps the count
        enable_i = 1'b0; req_i = 4'b1111;
        step();
        check_val("dis_run_gnt", gnt_o, 4'b0);
        check_val("dis_run_running", running_o, 1'b0);
        check_val("dis_run_lfsr_rst", lfsr_rst_o, 1'b1);
        check_val("dis_run_issued", issued_o, 32'd3);

        // Disable during WARMUP, then full re-run
        enable_i = 1'b1;
        step();
        repeat (26) step();
        check_val("in_warmup_rst", lfsr_rst_o, 1'b0);
        check_val("in_warmup_start", lfsr_start_o, 1'b0);
        enable_i = 1'b0;
        step();
        check_val("dis_wu_lfsr_rst", lfsr_rst_o, 1'b1);
        check_val("dis_wu_running", running_o, 1'b0);
        enable_i = 1'b1;
        step();
        bringup("reenable");
        check_val("issued_kept", issued_o, 32'd3);

        // Stuck-at-zero words
        req_i = 4'b0000; lfsr_out_i = 3'd0;
        repeat (39) step();
        check_val("zero39_lockup", lockup_o, 1'b0);
        check_val("zero39_running", running_o, 1'b1);
        step();
`ifdef LFSR_LOCKUP_DETECT_EN
        check_val("zero40_lockup", lockup_o, 1'b1);
        check_val("zero40_lfsr_rst", lfsr_rst_o, 1'b1);
        check_val("zero40_running", running_o, 1'b0);
`else
        check_val("zero40_lockup", lockup_o, 1'b0);
        check_val("zero40_running", running_o, 1'b1);
`endif
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        check_val("restart_lockup_clr", lockup_o, 1'b0);
        check_val("restart_lfsr_rst2", lfsr_rst_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lfsr_dither_sched.md
Name: lfsr_dither_sched

Overview:
Sequencer and arbiter for the SRL-based 3-bit tiny LFSR used by the AGC dither path. It owns the LFSR's reset and start lines and runs the bring-up sequence: flush, seed pulse, then warm-up until the 35-bit state is fully populated. Once running, it shares the free-running 3-bit random word among NUM_REQ consumers with round-robin grants. It sits between the AGC control registers and the per-channel dither injectors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FLUSH_CYCLES, 16, cycles lfsr_rst_o is held high; must be >= 13 (SRL depth 11 + tail + margin)
WARMUP_CYCLES, 64, cycles after the seed pulse before words are issued; must be >= 35
CNT_W, 32, width of the issued-word counter

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  level; 1 = run the LFSR, 0 = hold it in reset
restart_i  in  1  single-cycle pulse; re-runs the flush/seed/warm-up sequence
lfsr_rst_o  out  1  to LFSR rst_i
lfsr_start_o  out  1  to LFSR start_i
lfsr_out_i  in  3  from LFSR out_o[2:0] (bit 3 ignored)
req_i  in  NUM_REQ  per-requester request level
gnt_o  out  NUM_REQ  one-hot grant, 1-cycle pulse
data_o  out  3  random word that accompanies gnt_o
running_o  out  1  1 while in RUN
issued_o  out  CNT_W  count of granted words, saturating
lockup_o  out  1  sticky lockup flag (see Optional Feature)

Behaviour:
- Async reset values: state=IDLE, lfsr_rst_o=1, lfsr_start_o=0, gnt_o=0, data_o=0, running_o=0, issued_o=0, lockup_o=0, round-robin pointer=0.
- All outputs are registered.
- IDLE: lfsr_rst_o=1. If enable_i=1, go to FLUSH and load the counter with FLUSH_CYCLES-1.
- FLUSH: lfsr_rst_o=1. Count down; at 0 go to SEED.
- SEED: exactly one cycle with lfsr_rst_o=0 and lfsr_start_o=1. Load the counter with WARMUP_CYCLES-1, then go to WARMUP.
- WARMUP: lfsr_rst_o=0, lfsr_start_o=0, no grants. Count down; at 0 go to RUN.
- RUN: running_o=1. Each cycle, if any req_i bit is set, grant exactly one requester:
  - Search starts at the pointer; the winner is the first set bit going upward with wrap.
  - Pointer becomes winner+1 mod NUM_REQ.
  - Latency: req_i and lfsr_out_i are sampled in cycle n; gnt_o and data_o are valid in cycle n+1.
- If no requester is granted in a cycle: gnt_o=0, data_o holds its last value, and the LFSR word for that cycle is discarded (the LFSR free-runs).
- A requester holding req_i continuously is granted at most every NUM_REQ cycles while others are also requesting. With a single requester, it is granted every cycle.
- issued_o increments by 1 per grant and saturates at all-ones.
- issued_o clears only on rst_ni or restart_i.
- enable_i=0 in any state: next cycle go to IDLE, lfsr_rst_o=1, running_o=0, gnt_o=0. issued_o is preserved.
- restart_i=1 in FLUSH, SEED, WARMUP or RUN: next cycle go to FLUSH with the full FLUSH_CYCLES count. gnt_o=0 from that cycle on; issued_o and lockup_o clear.
- restart_i in IDLE: clears counters only.
- restart_i together with enable_i=0: enable_i wins, go to IDLE; counters still clear.
- A reset assertion in mid-sequence aborts immediately; there is no partial state.

Optional Feature:
Macro: LFSR_LOCKUP_DETECT_EN.
- Defined: a 6-bit counter counts consecutive RUN cycles with lfsr_out_i==3'b000.
  - The counter resets on any nonzero word.
  - When it reaches 40 (more than the LFSR length, so the register has collapsed to zero), set lockup_o=1 (sticky) and go to FLUSH automatically.
  - lockup_o clears on rst_ni or restart_i.
- Not defined: no counter is built, lockup_o is tied to 0, and a zero word is issued like any other.

Test Plan:
1. Reset then enable_i=1, defaults -> lfsr_rst_o high for 16 cycles, lfsr_start_o high for exactly 1 cycle, 64 cycles of WARMUP, then running_o=1; no gnt_o before RUN.
2. In RUN, req_i=4'b1111 held for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,... and each data_o equals lfsr_out_i from the previous cycle; issued_o=8.
3. In RUN, req_i=4'b0100 alone -> gnt_o=0100 every cycle; pointer wraps to 3. Then req_i=4'b1001 -> first grant 1000, then 0001.
4. restart_i pulse in mid-RUN with issued_o=20 -> gnt_o=0 next cycle, issued_o=0, full 16+1+64 sequence repeats, running_o rises after that.
5. enable_i dropped during WARMUP -> IDLE next cycle, lfsr_rst_o=1; re-enable restarts from FLUSH with the full counts.
6. With LFSR_LOCKUP_DETECT_EN defined, force lfsr_out_i=0 for 40 RUN cycles -> lockup_o=1 and FLUSH entered. Without the macro, the same stimulus keeps RUN and lockup_o=0.
